// File: rtl/ladybird_decode_stage.sv
// RV32I decode stage: splits instruction words into fields and a sign-extended immediate,
// then holds the decoded entries in a 2-entry skid buffer so that i_ready comes from a register.
`timescale 1ns/1ps
module ladybird_decode_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            nrst,
  input  logic            flush,
  input  logic            i_valid,
  output logic            i_ready,
  input  logic [XLEN-1:0] i_pc,
  input  logic [31:0]     i_inst,
  output logic            o_valid,
  input  logic            o_ready,
  output logic [XLEN-1:0] o_pc,
  output logic [6:0]      o_opcode,
  output logic [4:0]      o_rd,
  output logic [4:0]      o_rs1,
  output logic [4:0]      o_rs2,
  output logic [2:0]      o_funct3,
  output logic [6:0]      o_funct7,
  output logic [XLEN-1:0] o_imm,
  output logic            o_illegal,
  output logic            o_is_ecall,
  output logic            o_is_ebreak
);

  localparam logic [6:0] OPC_LOAD     = 7'h03;
  localparam logic [6:0] OPC_MISC_MEM = 7'h0F;
  localparam logic [6:0] OPC_OP_IMM   = 7'h13;
  localparam logic [6:0] OPC_AUIPC    = 7'h17;
  localparam logic [6:0] OPC_STORE    = 7'h23;
  localparam logic [6:0] OPC_OP       = 7'h33;
  localparam logic [6:0] OPC_LUI      = 7'h37;
  localparam logic [6:0] OPC_BRANCH   = 7'h63;
  localparam logic [6:0] OPC_JALR     = 7'h67;
  localparam logic [6:0] OPC_JAL      = 7'h6F;
  localparam logic [6:0] OPC_SYSTEM   = 7'h73;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [6:0]      opcode;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] imm;
    logic            illegal;
    logic            is_ecall;
    logic            is_ebreak;
  } entry_t;

  typedef enum logic [1:0] {EMPTY, ONE, TWO} occ_t;

  logic [6:0]  w_op;
  logic [2:0]  w_f3;
  logic [6:0]  w_f7;
  logic        w_ecall;
  logic        w_ebreak;
  logic [31:0] w_imm32;
  logic        w_bad;
  entry_t      w_dec;
  logic        w_accept;
  logic        w_pop;

  occ_t   r_state;
  entry_t r_head;
  entry_t r_skid;
  logic   r_ready;

  assign w_op     = i_inst[6:0];
  assign w_f3     = i_inst[14:12];
  assign w_f7     = i_inst[31:25];
  assign w_ecall  = (i_inst == 32'h0000_0073);
  assign w_ebreak = (i_inst == 32'h0010_0073);

  // Every base opcode ends in 2'b11, so the opcode match also rejects compressed encodings.
  always_comb begin
    w_imm32 = '0;
    w_bad   = 1'b0;
    case (w_op)
      OPC_LOAD: begin
        w_imm32 = {{20{i_inst[31]}}, i_inst[31:20]};
        w_bad   = (w_f3 == 3'd3) || (w_f3 == 3'd6) || (w_f3 == 3'd7);
      end
      OPC_MISC_MEM: w_imm32 = {{20{i_inst[31]}}, i_inst[31:20]};
      OPC_OP_IMM: begin
        w_imm32 = {{20{i_inst[31]}}, i_inst[31:20]};
        w_bad   = ((w_f3 == 3'd1) && (w_f7 != 7'h00)) ||
                  ((w_f3 == 3'd5) && (w_f7 != 7'h00) && (w_f7 != 7'h20));
      end
      OPC_AUIPC, OPC_LUI: w_imm32 = {i_inst[31:12], 12'b0};
      OPC_STORE: begin
        w_imm32 = {{20{i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
        w_bad   = (w_f3 > 3'd2);
      end
      OPC_OP: begin
        w_bad = ((w_f7 != 7'h00) && (w_f7 != 7'h20)) ||
                ((w_f7 == 7'h20) && (w_f3 != 3'd0) && (w_f3 != 3'd5));
      end
      OPC_BRANCH: begin
        w_imm32 = {{19{i_inst[31]}}, i_inst[31], i_inst[7], i_inst[30:25], i_inst[11:8], 1'b0};
        w_bad   = (w_f3 == 3'd2) || (w_f3 == 3'd3);
      end
      OPC_JALR: begin
        w_imm32 = {{20{i_inst[31]}}, i_inst[31:20]};
        w_bad   = (w_f3 != 3'd0);
      end
      OPC_JAL: w_imm32 = {{11{i_inst[31]}}, i_inst[31], i_inst[19:12], i_inst[20], i_inst[30:21], 1'b0};
      OPC_SYSTEM: begin
        w_imm32 = {{20{i_inst[31]}}, i_inst[31:20]};
        w_bad   = (w_f3 == 3'd0) && !w_ecall && !w_ebreak;
      end
      default: w_bad = 1'b1;
    endcase
  end

  always_comb begin
    w_dec           = '0;
    w_dec.pc        = i_pc;
    w_dec.opcode    = w_op;
    w_dec.rd        = i_inst[11:7];
    w_dec.rs1       = i_inst[19:15];
    w_dec.rs2       = i_inst[24:20];
    w_dec.funct3    = w_f3;
    w_dec.funct7    = w_f7;
    w_dec.imm       = XLEN'($signed(w_imm32));
    w_dec.illegal   = w_bad;
    w_dec.is_ecall  = w_ecall;
    w_dec.is_ebreak = w_ebreak;
  end

  assign w_accept = i_valid & r_ready;
  assign w_pop    = o_valid & o_ready;

  // r_ready tracks (next state != TWO) so i_ready never depends on o_ready combinationally.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state <= EMPTY;
      r_head  <= '0;
      r_skid  <= '0;
      r_ready <= 1'b1;
    end else if (flush) begin
      r_state <= EMPTY;
      r_ready <= 1'b1;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_accept) begin
            r_head  <= w_dec;
            r_state <= ONE;
          end
        end
        ONE: begin
          case ({w_accept, w_pop})
            2'b10: begin
              r_skid  <= w_dec;
              r_state <= TWO;
              r_ready <= 1'b0;
            end
            2'b01: r_state <= EMPTY;
            2'b11: r_head <= w_dec;
            default: ;
          endcase
        end
        TWO: begin
          if (w_pop) begin
            r_head  <= r_skid;
            r_state <= ONE;
            r_ready <= 1'b1;
          end
        end
        default: begin
          r_state <= EMPTY;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  assign i_ready     = r_ready;
  assign o_valid     = (r_state != EMPTY);
  assign o_pc        = r_head.pc;
  assign o_opcode    = r_head.opcode;
  assign o_rd        = r_head.rd;
  assign o_rs1       = r_head.rs1;
  assign o_rs2       = r_head.rs2;
  assign o_funct3    = r_head.funct3;
  assign o_funct7    = r_head.funct7;
  assign o_imm       = r_head.imm;
  assign o_illegal   = r_head.illegal;
  assign o_is_ecall  = r_head.is_ecall;
  assign o_is_ebreak = r_head.is_ebreak;

endmodule

// File: tb/tb_ladybird_decode_stage.sv
// Directed and randomized-handshake bench for ladybird_decode_stage; expected entries come from
// instruction constructors in this bench, not from the DUT.
`timescale 1ns/1ps
module tb_ladybird_decode_stage;

  localparam int XLEN = 32;
  typedef logic [98:0] ent_t;

  logic            clk = 1'b0;
  logic            nrst;
  logic            flush;
  logic            i_valid;
  logic            i_ready;
  logic [XLEN-1:0] i_pc;
  logic [31:0]     i_inst;
  logic            o_valid;
  logic            o_ready;
  logic [XLEN-1:0] o_pc;
  logic [6:0]      o_opcode;
  logic [4:0]      o_rd;
  logic [4:0]      o_rs1;
  logic [4:0]      o_rs2;
  logic [2:0]      o_funct3;
  logic [6:0]      o_funct7;
  logic [XLEN-1:0] o_imm;
  logic            o_illegal;
  logic            o_is_ecall;
  logic            o_is_ebreak;

  int n_compared   = 0;
  int n_mismatched = 0;

  ladybird_decode_stage #(.XLEN(XLEN)) dut (
    .clk(clk), .nrst(nrst), .flush(flush),
    .i_valid(i_valid), .i_ready(i_ready), .i_pc(i_pc), .i_inst(i_inst),
    .o_valid(o_valid), .o_ready(o_ready), .o_pc(o_pc), .o_opcode(o_opcode),
    .o_rd(o_rd), .o_rs1(o_rs1), .o_rs2(o_rs2), .o_funct3(o_funct3), .o_funct7(o_funct7),
    .o_imm(o_imm), .o_illegal(o_illegal), .o_is_ecall(o_is_ecall), .o_is_ebreak(o_is_ebreak)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [31:0] pc, input logic [31:0] inst);
    i_valid = 1'b1;
    i_pc    = pc;
    i_inst  = inst;
    @(negedge clk);
    i_valid = 1'b0;
    $display("xfer pc=%08h inst=%08h -> valid=%0b illegal=%0b imm=%08h", pc, inst, o_valid, o_illegal, o_imm);
  endtask

  task automatic idle();
    i_valid = 1'b0;
    o_ready = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  function automatic ent_t observed();
    return {o_pc, o_opcode, o_rd, o_rs1, o_rs2, o_funct3, o_funct7, o_imm,
            o_illegal, o_is_ecall, o_is_ebreak};
  endfunction

  // Builds a random legal RV32I word and the immediate it was constructed from.
  task automatic gen_word(output logic [31:0] w, output logic [31:0] imm);
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [11:0] i12;
    logic [12:0] b13;
    logic [19:0] u20;
    logic [20:0] j21;
    int          sel;
    rd  = 5'($urandom);
    rs1 = 5'($urandom);
    rs2 = 5'($urandom);
    i12 = 12'($urandom);
    u20 = 20'($urandom);
    b13 = {12'($urandom), 1'b0};
    j21 = {20'($urandom), 1'b0};
    sel = $urandom_range(0, 5);
    case ($urandom_range(0, 6))
      0: begin
        case (sel) 0: f3 = 3'd0; 1: f3 = 3'd2; 2: f3 = 3'd3; 3: f3 = 3'd4; 4: f3 = 3'd6; default: f3 = 3'd7; endcase
        w = {i12, rs1, f3, rd, 7'h13};
        imm = {{20{i12[11]}}, i12};
      end
      1: begin
        case (sel) 0: f3 = 3'd0; 1: f3 = 3'd1; 2: f3 = 3'd2; 3: f3 = 3'd4; default: f3 = 3'd5; endcase
        w = {i12, rs1, f3, rd, 7'h03};
        imm = {{20{i12[11]}}, i12};
      end
      2: begin
        f3 = 3'($urandom_range(0, 2));
        w = {i12[11:5], rs2, rs1, f3, i12[4:0], 7'h23};
        imm = {{20{i12[11]}}, i12};
      end
      3: begin
        case (sel) 0: f3 = 3'd0; 1: f3 = 3'd1; 2: f3 = 3'd4; 3: f3 = 3'd5; 4: f3 = 3'd6; default: f3 = 3'd7; endcase
        w = {b13[12], b13[10:5], rs2, rs1, f3, b13[4:1], b13[11], 7'h63};
        imm = {{19{b13[12]}}, b13};
      end
      4: begin
        w = {u20, rd, ($urandom_range(0, 1) == 0) ? 7'h37 : 7'h17};
        imm = {u20, 12'h000};
      end
      5: begin
        w = {j21[20], j21[10:1], j21[11], j21[19:12], rd, 7'h6F};
        imm = {{11{j21[20]}}, j21};
      end
      default: begin
        if ($urandom_range(0, 1) == 0) begin
          f7 = 7'h00;
          f3 = 3'($urandom);
        end else begin
          f7 = 7'h20;
          f3 = ($urandom_range(0, 1) == 0) ? 3'd0 : 3'd5;
        end
        w = {f7, rs2, rs1, f3, rd, 7'h33};
        imm = 32'h0;
      end
    endcase
  endtask

  initial begin
    nrst = 1'b0; flush = 1'b0; i_valid = 1'b0; o_ready = 1'b0;
    i_pc = '0; i_inst = '0;
    @(negedge clk);
    check("rst_o_valid", o_valid, 0);
    check("rst_i_ready", i_ready, 1);
    check("rst_fields", observed(), 0);
    nrst = 1'b1;

    // Basic decode, one-cycle latency
    o_ready = 1'b1;
    push(32'h8000_0000, 32'hFFF1_0093);
    check("addi_valid", o_valid, 1);
    check("addi_pc", o_pc, 32'h8000_0000);
    check("addi_opcode", o_opcode, 7'h13);
    check("addi_rd", o_rd, 1);
    check("addi_rs1", o_rs1, 2);
    check("addi_f3", o_funct3, 0);
    check("addi_imm", o_imm, 32'hFFFF_FFFF);
    check("addi_illegal", o_illegal, 0);
    push(32'h8000_0004, 32'hFE20_8EE3);
    check("beq_rs1", o_rs1, 1);
    check("beq_rs2", o_rs2, 2);
    check("beq_imm", o_imm, 32'hFFFF_FFFC);
    push(32'h8000_0008, 32'h1234_52B7);
    check("lui_rd", o_rd, 5);
    check("lui_imm", o_imm, 32'h1234_5000);
    check("lui_opcode", o_opcode, 7'h37);

    // Illegal / system encodings
    push(32'h10, 32'h0000_0000);  check("ill_zero", o_illegal, 1);
    push(32'h14, 32'h0000_707F);  check("ill_7f", o_illegal, 1);
    push(32'h18, 32'h4000_1033);  check("ill_subsll", o_illegal, 1);
    check("ill_subsll_f7", o_funct7, 7'h20);
    push(32'h1C, 32'h0000_1067);  check("ill_jalr_f3", o_illegal, 1);
    push(32'h20, 32'h0200_1013);  check("ill_slli_f7", o_illegal, 1);
    push(32'h24, 32'h4000_5013);  check("srai_legal", o_illegal, 0);
    push(32'h28, 32'h0000_3003);  check("ill_load_f3", o_illegal, 1);
    push(32'h2C, 32'h0000_0073);
    check("ecall_flag", o_is_ecall, 1);
    check("ecall_legal", o_illegal, 0);
    push(32'h30, 32'h0010_0073);
    check("ebreak_flag", o_is_ebreak, 1);
    check("ebreak_ecall", o_is_ecall, 0);
    check("ebreak_legal", o_illegal, 0);
    push(32'h34, 32'h0020_0073);  check("ill_system", o_illegal, 1);

    // Backpressure: two words fill the buffer, the third stalls
    idle();
    o_ready = 1'b0;
    i_valid = 1'b1; i_inst = 32'hFFF1_0093; i_pc = 32'h100;
    @(negedge clk);
    check("stall_rdy_one", i_ready, 1);
    i_pc = 32'h104;
    @(negedge clk);
    check("stall_rdy_two", i_ready, 0);
    i_pc = 32'h108;
    @(negedge clk);
    check("stall_rdy_hold", i_ready, 0);
    check("stall_head", o_pc, 32'h100);
    o_ready = 1'b1;
    @(negedge clk);
    check("drain_2", o_pc, 32'h104);
    check("drain_rdy", i_ready, 1);
    @(negedge clk);
    check("drain_3", o_pc, 32'h108);
    i_valid = 1'b0;
    @(negedge clk);
    check("drain_empty", o_valid, 0);

    // Flush from a full buffer while a word is offered
    o_ready = 1'b0;
    push(32'h200, 32'hFFF1_0093);
    push(32'h204, 32'hFFF1_0093);
    check("flush_pre_full", i_ready, 0);
    flush = 1'b1; i_valid = 1'b1; i_pc = 32'h208;
    @(negedge clk);
    flush = 1'b0; i_valid = 1'b0;
    check("flush_valid", o_valid, 0);
    check("flush_ready", i_ready, 1);
    o_ready = 1'b1;
    @(negedge clk);
    check("flush_stays_empty", o_valid, 0);
    flush = 1'b1; i_valid = 1'b1; i_pc = 32'h20C;
    @(negedge clk);
    flush = 1'b0; i_valid = 1'b0;
    check("flush_drops_accept", o_valid, 0);
    push(32'h210, 32'h1234_52B7);
    check("post_flush_pc", o_pc, 32'h210);

    // Asynchronous reset between edges
    idle();
    o_ready = 1'b0;
    push(32'h300, 32'hFE20_8EE3);
    push(32'h304, 32'hFE20_8EE3);
    #2 nrst = 1'b0;
    #1;
    check("arst_valid", o_valid, 0);
    check("arst_ready", i_ready, 1);
    check("arst_pc", o_pc, 0);
    @(negedge clk);
    nrst = 1'b1;

    // Random handshakes over 1000 constructed words
    begin
      ent_t        q[$];
      ent_t        exp_e;
      logic [31:0] cur_w, cur_imm, cur_pc;
      bit          have = 1'b0;
      int          sent = 0, rcvd = 0, cyc = 0;
      @(negedge clk);
      while (rcvd < 1000 && cyc < 20000) begin
        if (!have && sent < 1000) begin
          gen_word(cur_w, cur_imm);
          cur_pc = 32'h1000 + 32'(sent) * 4;
          have = 1'b1;
        end
        i_valid = have && ($urandom_range(0, 3) != 0);
        i_pc    = cur_pc;
        i_inst  = cur_w;
        o_ready = ($urandom_range(0, 2) != 0);
        #1;
        if (o_valid && o_ready) begin
          if (q.size() == 0) begin
            check("rand_underflow", q.size(), 1);
          end else begin
            exp_e = q.pop_front();
            check("rand_entry", observed(), exp_e);
            $display("rand rx %0d pc=%08h inst_op=%02h imm=%08h", rcvd, o_pc, o_opcode, o_imm);
          end
          rcvd++;
        end
        if (i_valid && i_ready) begin
          q.push_back({cur_pc, cur_w[6:0], cur_w[11:7], cur_w[19:15], cur_w[24:20],
                       cur_w[14:12], cur_w[31:25], cur_imm, 3'b000});
          sent++;
          have = 1'b0;
        end
        @(negedge clk);
        cyc++;
      end
      check("rand_count", rcvd, 1000);
      check("rand_leftover", q.size(), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/ladybird_decode_stage.md
Name: ladybird_decode_stage

Overview:
Pipeline stage that decodes 32-bit RV32I instruction words back into fields and a sign-extended immediate. It is the inverse of the instruction constructors in ladybird_config. It sits between instruction fetch and execute. Upstream and downstream use valid/ready handshakes, with a 2-entry skid buffer so that i_ready is driven from a register. Illegal encodings are flagged, not dropped.

Parameters:
XLEN, 32, datapath width; pc and immediate width.

Ports:
clk  in  1  clock
nrst  in  1  asynchronous active-low reset
flush  in  1  synchronous pipeline flush
i_valid  in  1  upstream word valid
i_ready  out  1  stage can accept a word
i_pc  in  XLEN  pc of the word
i_inst  in  32  raw instruction word
o_valid  out  1  decoded entry valid
o_ready  in  1  downstream accepts
o_pc  out  XLEN  pc passthrough
o_opcode  out  7  inst[6:0]
o_rd  out  5  inst[11:7]
o_rs1  out  5  inst[19:15]
o_rs2  out  5  inst[24:20]
o_funct3  out  3  inst[14:12]
o_funct7  out  7  inst[31:25]
o_imm  out  XLEN  sign-extended immediate
o_illegal  out  1  illegal encoding
o_is_ecall  out  1  word == 0x00000073
o_is_ebreak  out  1  word == 0x00100073

Behaviour:
- Reset (nrst=0, async):
  - Both buffer entries are invalid.
  - All outputs are 0, except i_ready=1.
- Handshakes:
  - Upstream transfer occurs when i_valid & i_ready.
  - Downstream transfer occurs when o_valid & o_ready.
  - Latency is 1 cycle: a word accepted at edge N appears on o_* after edge N if the buffer was empty.
- Buffer state is an occupancy counter: EMPTY, ONE, TWO.
  - EMPTY -> ONE on an accept.
  - ONE -> TWO on an accept without a pop.
  - ONE -> EMPTY on a pop without an accept.
  - ONE stays ONE on a simultaneous accept and pop.
  - TWO -> ONE on a pop; the skid entry moves to the output entry.
- i_ready = (state != TWO). It is registered; no combinational path from o_ready.
- o_valid = (state != EMPTY). Output fields are stable while o_valid & !o_ready.
- Order is strictly FIFO. Decode happens at the input, so the buffer holds already-decoded entries.
- Immediate selection, all formats sign-extended from inst[31]:
  - I-type: LOAD, OP_IMM, JALR, SYSTEM, MISC_MEM.
  - S-type: STORE.
  - B-type: BRANCH; bit0=0.
  - U-type: LUI, AUIPC; low 12 bits = 0.
  - J-type: JAL; bit0=0.
  - OP: immediate = 0.
- o_illegal=1 if any of the following holds:
  - inst[1:0] != 2'b11, or opcode is not one of the 11 RV32I base opcodes.
  - LOAD with funct3 in {3,6,7}.
  - STORE with funct3 > 2.
  - BRANCH with funct3 in {2,3}.
  - JALR with funct3 != 0.
  - OP with funct7 not in {0x00, 0x20}, or funct7 = 0x20 with funct3 not in {0,5}.
  - OP_IMM funct3=1 with funct7 != 0.
  - OP_IMM funct3=5 with funct7 not in {0x00, 0x20}.
  - SYSTEM with funct3=0 that is neither ECALL nor EBREAK.
- Illegal words still pass through with all fields populated.
- flush=1: at the next edge both entries are invalidated and state becomes EMPTY. A word presented with i_valid & i_ready in the flush cycle is discarded. flush has priority over accept and pop.
- An async reset in mid-transfer discards all contents immediately.

Test Plan:
- Reset, then i_inst=0xFFF10093 (ADDI x1,x2,-1) at pc 0x80000000 -> after 1 cycle o_valid=1, opcode=0x13, rd=1, rs1=2, funct3=0, imm=0xFFFFFFFF, illegal=0.
- i_inst=0xFE208EE3 (BEQ x1,x2,-4) -> rs1=1, rs2=2, imm=0xFFFFFFFC. Then 0x123452B7 (LUI x5,0x12345) -> rd=5, imm=0x12345000.
- Hold o_ready=0 and offer 3 words back-to-back -> words 1 and 2 accepted, i_ready=0 on cycle 3, word 3 stalled. Raise o_ready -> outputs appear in order 1, 2, 3 with no loss or duplication.
- 0x00000000, 0x0000707F, 0x40001033 (SUB-encoded SLL) -> o_illegal=1 for each. 0x00000073 -> o_is_ecall=1. 0x00100073 -> o_is_ebreak=1, o_illegal=0.
- Buffer in state TWO, assert flush with i_valid=1 -> next cycle o_valid=0, i_ready=1, and the flush-cycle word never appears.
- Random valid/ready toggling over 1000 words, checked against a reference decoder built from the ladybird_config constructors -> all fields match and order is preserved.
